// File: rtl/lr_shift_arbiter_pkg.sv
// Shared types for the two-requester left/right shift arbiter.
// Shift direction encoding is shared with the shifter.
package lr_shift_arbiter_pkg;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } shift_dir_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_ISSUE2 = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  localparam logic ID_REQ0 = 1'b0;
  localparam logic ID_REQ1 = 1'b1;

  function automatic int clog2(input int w);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < w) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/lr_shift_arbiter_if.sv
// Request, response and shifter bundle for lr_shift_arbiter.
// Rotate inputs exist only with LR_SHIFT_ARB_ROTATE_EN.
interface lr_shift_arbiter_if
  import lr_shift_arbiter_pkg::*;
#(
  parameter int width = 8
) ();
  localparam int SW = clog2(width);

  logic             req0_valid;
  logic             req0_ready;
  logic [width-1:0] req0_bits;
  logic [SW-1:0]    req0_shift;
  logic             req0_dir;
  logic             req1_valid;
  logic             req1_ready;
  logic [width-1:0] req1_bits;
  logic [SW-1:0]    req1_shift;
  logic             req1_dir;
`ifdef LR_SHIFT_ARB_ROTATE_EN
  logic             req0_rot;
  logic             req1_rot;
`endif
  logic             rsp_valid;
  logic             rsp_ready;
  logic [width-1:0] rsp_bits;
  logic             rsp_id;
  logic [width-1:0] sh_iBits;
  logic [SW-1:0]    sh_shift;
  logic             sh_dir;
  logic [width-1:0] sh_oBits;

  modport slave (
    input  req0_valid, req0_bits,
    input  req0_shift, req0_dir,
    input  req1_valid, req1_bits,
    input  req1_shift, req1_dir,
`ifdef LR_SHIFT_ARB_ROTATE_EN
    input  req0_rot, req1_rot,
`endif
    input  rsp_ready, sh_oBits,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_bits, rsp_id,
    output sh_iBits, sh_shift, sh_dir
  );

  modport master (
    output req0_valid, req0_bits,
    output req0_shift, req0_dir,
    output req1_valid, req1_bits,
    output req1_shift, req1_dir,
`ifdef LR_SHIFT_ARB_ROTATE_EN
    output req0_rot, req1_rot,
`endif
    output rsp_ready, sh_oBits,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_bits, rsp_id,
    input  sh_iBits, sh_shift, sh_dir
  );

endinterface

// File: rtl/lr_shift_arbiter_rr_arb2.sv
// Two-way round-robin grant; the last-grant state lives in the parent.
module rr_arb2
  import lr_shift_arbiter_pkg::*;
(
  input  logic [1:0] i_valid,
  input  logic       i_last_grant,
  output logic       o_gnt_valid,
  output logic       o_gnt_id
);

  always_comb begin
    o_gnt_valid = |i_valid;
    o_gnt_id    = ID_REQ0;
    unique case (1'b1)
      (i_valid == 2'b11): o_gnt_id = ~i_last_grant;
      (i_valid == 2'b10): o_gnt_id = ID_REQ1;
      default:            o_gnt_id = ID_REQ0;
    endcase
  end

endmodule

// File: rtl/lr_shift_arbiter.sv
// Shares one combinational left/right shifter between two requesters.
// Define LR_SHIFT_ARB_ROTATE_EN to add two-pass rotate operations.
module lr_shift_arbiter
  import lr_shift_arbiter_pkg::*;
#(
  parameter int width = 8
) (
  input logic            clk,
  input logic            rst,
  lr_shift_arbiter_if.slave bus
);
  localparam int SW = clog2(width);

  state_e           r_state;
  state_e           w_next;
  logic             r_last_grant;
  logic             r_op_id;
  logic             r_op_dir;
  logic [SW-1:0]    r_op_shift;
  logic [width-1:0] r_op_bits;
  logic [width-1:0] r_rsp_bits;
  logic             r_rsp_id;
  logic             w_gnt_valid;
  logic             w_gnt_id;
  logic             w_ready0;
  logic             w_ready1;
  logic             w_accept;
  logic [width-1:0] w_sel_bits;
  logic [SW-1:0]    w_sel_shift;
  logic             w_sel_dir;
`ifdef LR_SHIFT_ARB_ROTATE_EN
  logic             r_op_rot;
  logic [width-1:0] r_tmp;
  logic             w_sel_rot;
  int               w_rot_int;
  logic [SW-1:0]    w_rot_amt;
`endif

  rr_arb2 u_arb (
    .i_valid     ({bus.req1_valid, bus.req0_valid}),
    .i_last_grant(r_last_grant),
    .o_gnt_valid (w_gnt_valid),
    .o_gnt_id    (w_gnt_id)
  );

  assign w_sel_bits  = w_gnt_id ? bus.req1_bits  : bus.req0_bits;
  assign w_sel_shift = w_gnt_id ? bus.req1_shift : bus.req0_shift;
  assign w_sel_dir   = w_gnt_id ? bus.req1_dir   : bus.req0_dir;
`ifdef LR_SHIFT_ARB_ROTATE_EN
  assign w_sel_rot   = w_gnt_id ? bus.req1_rot   : bus.req0_rot;

  // Second rotate pass: opposite direction, complementary amount.
  always_comb begin
    w_rot_int = (width - int'(r_op_shift)) % width;
    w_rot_amt = w_rot_int[SW-1:0];
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (1'b1)
      (r_state == ST_IDLE):
        if (w_accept) w_next = ST_ISSUE;
      (r_state == ST_ISSUE):
`ifdef LR_SHIFT_ARB_ROTATE_EN
        w_next = r_op_rot ? ST_ISSUE2 : ST_RESP;
`else
        w_next = ST_RESP;
`endif
      (r_state == ST_ISSUE2):
        w_next = ST_RESP;
      default:
        if (bus.rsp_ready) w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_ready0 = 1'b0;
    w_ready1 = 1'b0;
    if (r_state == ST_IDLE && !rst && w_gnt_valid) begin
      w_ready0 = (w_gnt_id == ID_REQ0);
      w_ready1 = (w_gnt_id == ID_REQ1);
    end
  end

  assign w_accept = (w_ready0 & bus.req0_valid)
                  | (w_ready1 & bus.req1_valid);

  assign bus.req0_ready = w_ready0;
  assign bus.req1_ready = w_ready1;
  assign bus.rsp_valid  = (r_state == ST_RESP) && !rst;
  assign bus.rsp_bits   = r_rsp_bits;
  assign bus.rsp_id     = r_rsp_id;
  assign bus.sh_iBits   = r_op_bits;
  assign bus.sh_shift   = r_op_shift;
  assign bus.sh_dir     = r_op_dir;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= ID_REQ1;
      r_op_id      <= ID_REQ0;
      r_op_dir     <= DIR_LEFT;
      r_op_shift   <= '0;
      r_op_bits    <= '0;
      r_rsp_bits   <= '0;
      r_rsp_id     <= ID_REQ0;
`ifdef LR_SHIFT_ARB_ROTATE_EN
      r_op_rot     <= 1'b0;
      r_tmp        <= '0;
`endif
    end else begin
      if (w_accept) begin
        r_last_grant <= w_gnt_id;
        r_op_id      <= w_gnt_id;
        r_op_bits    <= w_sel_bits;
        r_op_shift   <= w_sel_shift;
        r_op_dir     <= w_sel_dir;
`ifdef LR_SHIFT_ARB_ROTATE_EN
        r_op_rot     <= w_sel_rot;
`endif
      end
      if (r_state == ST_ISSUE) begin
`ifdef LR_SHIFT_ARB_ROTATE_EN
        if (r_op_rot) begin
          r_tmp      <= bus.sh_oBits;
          r_op_dir   <= ~r_op_dir;
          r_op_shift <= w_rot_amt;
        end else begin
          r_rsp_bits <= bus.sh_oBits;
          r_rsp_id   <= r_op_id;
        end
`else
        r_rsp_bits <= bus.sh_oBits;
        r_rsp_id   <= r_op_id;
`endif
      end
`ifdef LR_SHIFT_ARB_ROTATE_EN
      if (r_state == ST_ISSUE2) begin
        r_rsp_bits <= r_tmp | bus.sh_oBits;
        r_rsp_id   <= r_op_id;
      end
`endif
    end
  end

endmodule

// File: tb/tb_lr_shift_arbiter.sv
// Scoreboard bench for lr_shift_arbiter with a behavioural shifter.
// Rotate vectors run only with LR_SHIFT_ARB_ROTATE_EN.
module tb_lr_shift_arbiter;
  import lr_shift_arbiter_pkg::*;

  localparam int W  = 8;

  typedef struct {
    logic [W-1:0] bits;
    logic         id;
    int           due;
  } exp_t;

  typedef struct {
    logic         id;
    logic [W-1:0] b;
    logic [2:0]   s;
    logic         d;
    logic         r;
    logic [W-1:0] e;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  exp_t         sb[$];
  logic         gq[$];
  int           acc_cyc[$];
  logic [W-1:0] exp0, exp1;
  int           lat0 = 2;
  int           lat1 = 2;
  logic         prev_v = 1'b0;
  exp_t         mon_e;
  vec_t         vt[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  lr_shift_arbiter_if #(.width(W)) bus ();

  lr_shift_arbiter #(.width(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always_comb begin
    if (bus.sh_dir == DIR_RIGHT)
      bus.sh_oBits = bus.sh_iBits >> bus.sh_shift;
    else
      bus.sh_oBits = bus.sh_iBits << bus.sh_shift;
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.req0_valid && bus.req0_ready) begin
        sb.push_back('{bits: exp0, id: 1'b0,
                       due: cyc + lat0});
        gq.push_back(1'b0);
        acc_cyc.push_back(cyc);
      end
      if (bus.req1_valid && bus.req1_ready) begin
        sb.push_back('{bits: exp1, id: 1'b1,
                       due: cyc + lat1});
        gq.push_back(1'b1);
        acc_cyc.push_back(cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (bus.rsp_valid && !prev_v) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rsp_unexpected: got bits %0h id %0h",
                   bus.rsp_bits, bus.rsp_id);
        end else begin
          check("rsp_latency", cyc, sb[0].due);
        end
      end
      if (bus.rsp_valid && bus.rsp_ready && sb.size() > 0) begin
        mon_e = sb.pop_front();
        check("rsp_bits", bus.rsp_bits, mon_e.bits);
        check("rsp_id", bus.rsp_id, mon_e.id);
      end
      prev_v = bus.rsp_valid && !bus.rsp_ready;
    end
  end

  task automatic wait_acc(input int target, input int budget);
    int k;
    k = 0;
    while (acc_cyc.size() < target && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (acc_cyc.size() < target) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got %0d accepts expected %0d",
               acc_cyc.size(), target);
    end
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while (sb.size() > 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d pending expected 0",
               sb.size());
      sb.delete();
    end
  endtask

  task automatic set_port(input vec_t v);
    if (v.id == 1'b0) begin
      bus.req0_bits  = v.b;
      bus.req0_shift = v.s;
      bus.req0_dir   = v.d;
`ifdef LR_SHIFT_ARB_ROTATE_EN
      bus.req0_rot   = v.r;
`endif
      exp0 = v.e;
      lat0 = v.r ? 3 : 2;
      bus.req0_valid = 1'b1;
    end else begin
      bus.req1_bits  = v.b;
      bus.req1_shift = v.s;
      bus.req1_dir   = v.d;
`ifdef LR_SHIFT_ARB_ROTATE_EN
      bus.req1_rot   = v.r;
`endif
      exp1 = v.e;
      lat1 = v.r ? 3 : 2;
      bus.req1_valid = 1'b1;
    end
  endtask

  task automatic drive(input vec_t v, input bit keep);
    int n;
    n = acc_cyc.size();
    set_port(v);
    @(negedge clk);
    check("ready_acc",
          v.id ? bus.req1_ready : bus.req0_ready, 1);
    wait_acc(n + 1, 30);
    if (!keep) begin
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
    end
  endtask

  initial begin
    int n;
    int k;
    logic [W-1:0] hb;
    logic hid;

    bus.req0_valid = 0; bus.req0_bits = '0;
    bus.req0_shift = '0; bus.req0_dir = 0;
    bus.req1_valid = 0; bus.req1_bits = '0;
    bus.req1_shift = '0; bus.req1_dir = 0;
`ifdef LR_SHIFT_ARB_ROTATE_EN
    bus.req0_rot = 0; bus.req1_rot = 0;
`endif
    bus.rsp_ready = 1'b1;

    vt.push_back('{1'b0, 8'h81, 3'd1, 1'b0, 1'b0, 8'h02});
    vt.push_back('{1'b1, 8'h81, 3'd3, 1'b1, 1'b0, 8'h10});
    vt.push_back('{1'b0, 8'hA5, 3'd4, 1'b1, 1'b0, 8'h0A});
    vt.push_back('{1'b1, 8'h3C, 3'd2, 1'b0, 1'b0, 8'hF0});
    vt.push_back('{1'b0, 8'hFF, 3'd7, 1'b0, 1'b0, 8'h80});
    vt.push_back('{1'b1, 8'hFF, 3'd0, 1'b1, 1'b0, 8'hFF});
    vt.push_back('{1'b1, 8'h80, 3'd7, 1'b1, 1'b0, 8'h01});
`ifdef LR_SHIFT_ARB_ROTATE_EN
    vt.push_back('{1'b0, 8'h81, 3'd1, 1'b0, 1'b1, 8'h03});
    vt.push_back('{1'b0, 8'h81, 3'd0, 1'b0, 1'b1, 8'h81});
    vt.push_back('{1'b1, 8'h81, 3'd3, 1'b1, 1'b1, 8'h30});
`endif

    // Reset state, with both requesters already asserting.
    set_port(vt[0]);
    set_port(vt[1]);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_bits", bus.rsp_bits, 0);
    check("rst_rsp_id", bus.rsp_id, 0);
    check("rst_ready0", bus.req0_ready, 0);
    check("rst_ready1", bus.req1_ready, 0);
    check("rst_sh_ibits", bus.sh_iBits, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Both valid, held: grants alternate starting with req0.
    wait_acc(4, 60);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    wait_drain(30);
    for (int i = 0; i < 4; i++) begin
      if (i < gq.size())
        check($sformatf("alt_grant%0d", i), gq[i], i % 2);
    end
    if (acc_cyc.size() >= 2)
      check("alt_spacing", acc_cyc[1] - acc_cyc[0], 3);

    // Single directed vectors, each from an idle FSM.
    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i], 1'b0);
      wait_drain(30);
    end

    // req1 again right after a req1 grant: no bubble.
    n = acc_cyc.size();
    drive(vt[1], 1'b1);
    wait_acc(n + 2, 30);
    bus.req1_valid = 1'b0;
    wait_drain(30);
    if (acc_cyc.size() >= n + 2)
      check("nobubble_gap",
            acc_cyc[n + 1] - acc_cyc[n], 3);

    // Back-pressure for 5 cycles with req1 waiting.
    bus.rsp_ready = 1'b0;
    drive(vt[2], 1'b0);
    set_port(vt[3]);
    k = 0;
    while (!bus.rsp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    hb  = bus.rsp_bits;
    hid = bus.rsp_id;
    check("bp_first_bits", hb, 8'h0A);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", bus.rsp_valid, 1);
      check("bp_bits", bus.rsp_bits, hb);
      check("bp_id", bus.rsp_id, hid);
      check("bp_ready0", bus.req0_ready, 0);
      check("bp_ready1", bus.req1_ready, 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.rsp_ready  = 1'b1;
    bus.req1_valid = 1'b0;
    wait_drain(10);

    // Reset while the operation sits in ISSUE.
    drive(vt[0], 1'b0);
    rst = 1'b1;
    sb.delete();
    set_port(vt[0]);
    set_port(vt[1]);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("abort_rsp_valid", bus.rsp_valid, 0);
    check("abort_rsp_bits", bus.rsp_bits, 0);
    check("abort_ready0", bus.req0_ready, 0);
    check("abort_sh_ibits", bus.sh_iBits, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    n = acc_cyc.size();
    wait_acc(n + 1, 10);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    wait_drain(20);
    if (gq.size() > n)
      check("abort_next_grant", gq[n], 0);
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
